// File: rtl/sn_to_bn.sv
// Stochastic-to-binary converter: counts ones in a 2**BN_W-bit stream opened by a start pulse.
// Optional build macro SN_BIPOLAR_EN selects bipolar decoding (count - LEN/2) of the result.
module sn_to_bn #(
    parameter int BN_W  = 4,
    parameter int CNT_W = BN_W + 1
) (
    input  logic             i_clk_sbc,
    input  logic             i_rst_sbc,
    input  logic             i_sn_bit,
    input  logic             i_start_sbc,
    input  logic             i_stop_sbc,
    output logic [CNT_W-1:0] o_x_bn,
    output logic             o_valid_sbc,
    output logic             o_busy_sbc
);

    localparam int LEN = 2 ** BN_W;
    localparam logic [BN_W-1:0] IDX_LAST = BN_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [BN_W-1:0]  r_idx;
    logic [BN_W-1:0]  w_idx_nxt;
    logic [CNT_W-1:0] r_x_bn;
    logic [CNT_W-1:0] w_x_bn_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    // Maps the final ones count onto the output encoding of this build.
    function automatic logic [CNT_W-1:0] decode_count(input logic [CNT_W-1:0] ones);
`ifdef SN_BIPOLAR_EN
        return ones - CNT_W'(LEN / 2);
`else
        return ones;
`endif
    endfunction

    assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, i_sn_bit};

    // Next-state, counter, index and result-load logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_x_bn_nxt  = r_x_bn;
        case (r_state)
            S_IDLE: begin
                if (i_start_sbc && !i_stop_sbc) begin
                    w_state_nxt = S_ACCUM;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_idx_nxt   = {BN_W{1'b0}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (i_stop_sbc) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_idx_nxt = r_idx + BN_W'(1);
                    // The last sample is folded into the result directly.
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_DONE;
                        w_x_bn_nxt  = decode_count(w_cnt_inc);
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end
            end
            S_DONE: begin
                if (i_stop_sbc) begin
                    w_state_nxt = S_IDLE;
                end else if (i_start_sbc) begin
                    w_state_nxt = S_ACCUM;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_idx_nxt   = {BN_W{1'b0}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_idx_nxt   = {BN_W{1'b0}};
            end
        endcase
        w_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt  = (w_state_nxt == S_ACCUM);
    end

    // State and output registers.
    always_ff @(posedge i_clk_sbc or posedge i_rst_sbc) begin
        if (i_rst_sbc) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_idx   <= {BN_W{1'b0}};
            r_x_bn  <= {CNT_W{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_x_bn  <= w_x_bn_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign o_x_bn      = r_x_bn;
    assign o_valid_sbc = r_valid;
    assign o_busy_sbc  = r_busy;

endmodule

// File: doc/sn_to_bn.md
# sn_to_bn

Stochastic-to-binary converter (SBC) that sits directly downstream of the stochastic number generator (SNG) in the `nn_wraper` datapath. It counts the ones in a fixed-length unipolar bitstream framed by a start pulse, then presents the result as a binary word with a one-cycle valid strobe. It closes the loop SNG → stochastic op → SBC, so the network's stochastic arithmetic can be read back in binary.

## Interface
- `BN_W`, 4: binary width of the SNG input; the stream length is `LEN = 2**BN_W` (16).
- `CNT_W`, `BN_W+1`: internal counter and output width; must hold `LEN`.

- `i_clk_sbc`  in  1  clock; all logic on the rising edge.
- `i_rst_sbc`  in  1  reset, asynchronous, active-high.
- `i_sn_bit`  in  1  stochastic bitstream, one bit per cycle; connects to SNG `o_sn_bit`.
- `i_start_sbc`  in  1  single-cycle pulse that opens a conversion window; same pulse as SNG start.
- `i_stop_sbc`  in  1  single-cycle abort.
- `o_x_bn`  out  `CNT_W`  converted value; holds between results.
- `o_valid_sbc`  out  1  one-cycle strobe; `o_x_bn` is new on this cycle.
- `o_busy_sbc`  out  1  high while the block is accumulating.

## Operation
- The FSM has three states:
  - IDLE: waits for a start pulse.
  - ACCUM: counts ones.
  - DONE: one cycle, presents the result.
- IDLE → ACCUM: on `i_start_sbc=1` and `i_stop_sbc=0`. On that edge the counter clears to 0 and the sample index clears to 0.
- ACCUM:
  - Each cycle, `cnt <= cnt + i_sn_bit` and `idx <= idx + 1`.
  - After the sample with `idx == LEN-1`, go to DONE and load `o_x_bn` with the final count, including that last bit.
- ACCUM → IDLE: on `i_stop_sbc=1`. The count is discarded, `o_x_bn` is unchanged and no valid strobe is issued.
- `i_start_sbc` is ignored in ACCUM. If start and stop arrive in the same cycle, stop wins.
- DONE:
  - `o_valid_sbc=1`. Next state is ACCUM if `i_start_sbc=1` (back-to-back window, counter cleared), else IDLE.
  - `i_stop_sbc` in DONE forces IDLE. The result is still valid this cycle.
- Arithmetic: the count is unsigned, 0..`LEN` (0..16), so `CNT_W` bits cannot overflow. There is no saturation.
- `o_busy_sbc = (state == ACCUM)`.
- Reset in any state: the FSM goes to IDLE immediately and the in-flight window is lost.

## Timing
- Reset values: `o_x_bn=0`, `o_valid_sbc=0`, `o_busy_sbc=0`, state IDLE, counter 0, index 0.
- Start sampled at rising edge k:
  - Bits are sampled at edges k+1 … k+LEN. This matches the registered SNG output, whose first bit is valid after edge k.
  - The result registers at edge k+LEN, giving `o_valid_sbc=1` during cycle k+LEN…k+LEN+1.
  - Latency from start to valid is `LEN` cycles (16).
- A start in the DONE cycle gives a continuous stream with no dead cycle. The next valid follows `LEN+1` cycles later.
- Outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro `SN_BIPOLAR_EN`.
- Defined: the stream is decoded as bipolar.
  - On the DONE load, `o_x_bn = cnt - LEN/2`, as `CNT_W`-bit two's complement, range −8..+8 for `BN_W=4`.
  - The value represented is `o_x_bn / (LEN/2)`.
- Undefined: unipolar, `o_x_bn = cnt`, range 0..16.
- The FSM, timing and strobes are identical in both builds.

## Test plan
- Unipolar window:
  - Drive SNG with `x=6`, pulse start at edge k and chain SNG to the SBC.
  - Required: `o_valid_sbc` high for exactly one cycle after edge k+16, `o_x_bn=6`, `o_busy_sbc` high for 16 cycles.
- Extremes:
  - Force `i_sn_bit=1` for the whole window: `o_x_bn=16`.
  - Force `i_sn_bit=0`: `o_x_bn=0`.
- Abort:
  - Complete one window with result 6, then start a new window and pulse stop 8 cycles in.
  - Required: no valid, `o_x_bn` stays 6, `o_busy_sbc` low the cycle after stop. A later start converts normally.
- Asynchronous reset:
  - Assert `i_rst_sbc` mid-window, between clock edges.
  - Required: all outputs go to 0 without waiting for a clock edge. After release, a start produces a correct 16-cycle conversion.
- Back-to-back and collisions:
  - Pulse start in the DONE cycle with 3 ones then 12 ones in the streams: valids spaced 17 cycles apart, values 3 then 12.
  - Start during ACCUM: ignored.
  - Start and stop together in IDLE: the block stays IDLE.
- `SN_BIPOLAR_EN` build:
  - 6 ones: `o_x_bn=5'b11110` (−2).
  - 16 ones: +8.
  - 8 ones: 0.
